mem_access_seq: RTL and testbench

//  Sequences every memory transaction of the multicycle CPU: instruction fetch, load, store, exception-vector read.

---
 rtl/mem_seq_pkg.sv | 63 ++++++
 rtl/mem_wait_cnt.sv | 24 ++
 rtl/mem_access_seq.sv | 108 ++++++++++
 tb/tb_mem_access_seq.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_seq_pkg.sv
// Shared codes for the memory access sequencer: request/size encodings, IorD selects, state enum.
package mem_seq_pkg;

  localparam int unsigned IORD_W = 3;

  typedef enum logic [1:0] {
    REQ_FETCH   = 2'd0,
    REQ_LOAD    = 2'd1,
    REQ_STORE   = 2'd2,
    REQ_EXC_VEC = 2'd3
  } req_type_e;

  typedef enum logic [1:0] {
    SIZE_WORD = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_BYTE = 2'd2,
    SIZE_RSVD = 2'd3
  } req_size_e;

  localparam logic [IORD_W-1:0] IORD_PC     = 3'd0;
  localparam logic [IORD_W-1:0] IORD_EXC    = 3'd1;
  localparam logic [IORD_W-1:0] IORD_ALURES = 3'd2;
  localparam logic [IORD_W-1:0] IORD_ALUOUT = 3'd3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_WAIT = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_MERGE   = 3'd3,
    ST_WRITE   = 3'd4,
    ST_FAULT   = 3'd5
  } state_e;

  typedef struct packed {
    req_type_e rtype;
    req_size_e rsize;
    logic      from_alu;
  } mem_req_t;

  // Reserved size code behaves as a full word.
  function automatic logic is_subword(input req_size_e s);
    return (s == SIZE_HALF) || (s == SIZE_BYTE);
  endfunction

  function automatic logic [IORD_W-1:0] iord_of(input mem_req_t r);
    case (r.rtype)
      REQ_FETCH:   return IORD_PC;
      REQ_EXC_VEC: return IORD_EXC;
      default:     return r.from_alu ? IORD_ALURES : IORD_ALUOUT;
    endcase
  endfunction

  function automatic logic misaligned(input mem_req_t r, input logic [1:0] lsb);
    logic data_access;
    data_access = (r.rtype == REQ_LOAD) || (r.rtype == REQ_STORE);
    case (r.rsize)
      SIZE_HALF: return data_access && lsb[0];
      SIZE_BYTE: return 1'b0;
      default:   return data_access && (lsb != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_cnt.sv
// Read wait-state counter: clears while idle, counts in RD_WAIT, flags the last wait cycle.
module mem_wait_cnt #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic term_c
);

  localparam int unsigned CW = $clog2(MEM_LAT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + CW'(1);
  end

  assign term_c = (cnt == CW'(MEM_LAT - 1));

endmodule

// File: rtl/mem_access_seq.sv
// Multicycle CPU memory transaction sequencer (fetch, load, store incl. sub-word RMW, exception vector).
// Define MEM_ALIGN_CHECK_EN to abort misaligned LOAD/STORE accesses through the FAULT state.
module mem_access_seq #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_type,
  input  logic [1:0] req_size,
  input  logic       addr_from_alu,
  input  logic [1:0] addr_lsb,
  output logic [2:0] iord_sel,
  output logic       mem_wr,
  output logic       ir_wr,
  output logic       mdr_wr,
  output logic       merge_en,
  output logic       done,
  output logic       misalign
);

  import mem_seq_pkg::*;

  state_e   state_q, state_d;
  mem_req_t req_in, req_q;
  logic     accept_c, term_c, align_fault_c;

  assign req_in   = {req_type, req_size, addr_from_alu};
  assign accept_c = req_valid && (state_q == ST_IDLE);

`ifdef MEM_ALIGN_CHECK_EN
  assign align_fault_c = misaligned(req_in, addr_lsb);
`else
  logic unused_lsb;
  assign unused_lsb    = ^addr_lsb;
  assign align_fault_c = 1'b0;
`endif

  mem_wait_cnt #(.MEM_LAT(MEM_LAT)) u_wait_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr    (state_q == ST_IDLE),
    .en     (state_q == ST_RD_WAIT),
    .term_c (term_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept_c) req_q <= req_in;
    end
  end

  // Word stores skip the read; sub-word stores read, merge, then write back.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (align_fault_c)
            state_d = ST_FAULT;
          else if (req_in.rtype == REQ_STORE && !is_subword(req_in.rsize))
            state_d = ST_WRITE;
          else
            state_d = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: if (term_c) state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = (req_q.rtype == REQ_STORE) ? ST_MERGE : ST_IDLE;
      ST_MERGE:   state_d = ST_WRITE;
      ST_WRITE:   state_d = ST_IDLE;
      ST_FAULT:   state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == ST_IDLE);
    iord_sel  = (state_q == ST_IDLE) ? IORD_PC : iord_of(req_q);
    mem_wr    = 1'b0;
    ir_wr     = 1'b0;
    mdr_wr    = 1'b0;
    merge_en  = 1'b0;
    done      = 1'b0;
    misalign  = 1'b0;
    case (state_q)
      ST_CAPTURE: begin
        if (req_q.rtype == REQ_FETCH) ir_wr  = 1'b1;
        else                          mdr_wr = 1'b1;
        done = (req_q.rtype != REQ_STORE);
      end
      ST_MERGE: merge_en = 1'b1;
      ST_WRITE: begin
        mem_wr = 1'b1;
        done   = 1'b1;
      end
`ifdef MEM_ALIGN_CHECK_EN
      ST_FAULT: misalign = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access_seq.sv
// Self-checking bench for mem_access_seq: vector table + completion scoreboard + hand-written corner cases.
module tb_mem_access_seq;

  localparam int LAT = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_type;
  logic [1:0] req_size;
  logic       addr_from_alu;
  logic [1:0] addr_lsb;
  logic [2:0] iord_sel;
  logic       mem_wr, ir_wr, mdr_wr, merge_en, done, misalign;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  mem_access_seq #(.MEM_LAT(LAT)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_type      (req_type),
    .req_size      (req_size),
    .addr_from_alu (addr_from_alu),
    .addr_lsb      (addr_lsb),
    .iord_sel      (iord_sel),
    .mem_wr        (mem_wr),
    .ir_wr         (ir_wr),
    .mdr_wr        (mdr_wr),
    .merge_en      (merge_en),
    .done          (done),
    .misalign      (misalign)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0] typ;
    logic [1:0] size;
    logic       alu;
    logic [1:0] lsb;
    int         iord;
    int         lat;
    bit         fault;
    bit         rmw;
  } vec_t;

  typedef struct {
    int acc;
    int iord;
    int lat;
    bit fault;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[12];

  task automatic chk(input string nm, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, got, exp, $time);
    end
  endtask

  function automatic int strb();
    return {28'd0, ir_wr, mdr_wr, merge_en, mem_wr};
  endfunction

  // Expected {ir_wr, mdr_wr, merge_en, mem_wr} at cycle k after accept.
  function automatic int exp_strb(input vec_t v, input int k);
    if (v.fault) return 0;
    if (v.rmw) begin
      if (k == LAT + 1) return 4;
      if (k == LAT + 2) return 2;
      if (k == LAT + 3) return 1;
      return 0;
    end
    if (v.typ == 2'd2) return (k == 1) ? 1 : 0;
    if (k == LAT + 1) return (v.typ == 2'd0) ? 8 : 4;
    return 0;
  endfunction

  function automatic vec_t mk(input logic [1:0] t, input logic [1:0] s, input logic a,
                              input logic [1:0] l, input int io, input int lt,
                              input bit f, input bit r);
    vec_t v;
    v.typ = t; v.size = s; v.alu = a; v.lsb = l;
    v.iord = io; v.lat = lt; v.fault = f; v.rmw = r;
    return v;
  endfunction

  task automatic drive(input logic [1:0] t, input logic [1:0] s, input logic a, input logic [1:0] l);
    req_valid = 1'b1; req_type = t; req_size = s; addr_from_alu = a; addr_lsb = l;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int  k;
    bit  fin;
    exp_t e;
    k = 0;
    while (!req_ready && k < 50) begin @(negedge clk); k++; end
    chk({nm, "_ready"}, int'(req_ready), 1);
    drive(v.typ, v.size, v.alu, v.lsb);
    e.acc = cyc; e.iord = v.iord; e.lat = v.lat; e.fault = v.fault;
    sb.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
    fin = 1'b0;
    for (k = 1; k <= 40 && !fin; k++) begin
      @(negedge clk);
      chk({nm, "_iord"}, int'(iord_sel), v.iord);
      chk({nm, "_strb"}, strb(), exp_strb(v, k));
      chk({nm, "_busy"}, int'(req_ready), 0);
      if (done || misalign) begin
        fin = 1'b1;
        if (sb.size() == 0) begin
          chk({nm, "_sb_nonempty"}, 0, 1);
        end else begin
          e = sb.pop_front();
          chk({nm, "_lat"}, cyc - e.acc, e.lat);
          chk({nm, "_kind"}, {30'd0, done, misalign}, e.fault ? 1 : 2);
          chk({nm, "_iord_end"}, int'(iord_sel), e.iord);
        end
      end
    end
    if (!fin) chk({nm, "_timeout"}, 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk(2'd0, 2'd0, 1'b0, 2'd0, 0, LAT + 1, 1'b0, 1'b0);  // FETCH
    vecs[1]  = mk(2'd1, 2'd0, 1'b0, 2'd0, 3, LAT + 1, 1'b0, 1'b0);  // LOAD WORD ALUOut
    vecs[2]  = mk(2'd1, 2'd2, 1'b1, 2'd3, 2, LAT + 1, 1'b0, 1'b0);  // LOAD BYTE odd addr
    vecs[3]  = mk(2'd2, 2'd0, 1'b1, 2'd0, 2, 1,       1'b0, 1'b0);  // STORE WORD
    vecs[4]  = mk(2'd2, 2'd2, 1'b1, 2'd1, 2, LAT + 3, 1'b0, 1'b1);  // STORE BYTE RMW
    vecs[5]  = mk(2'd2, 2'd1, 1'b0, 2'd2, 3, LAT + 3, 1'b0, 1'b1);  // STORE HALF RMW
    vecs[6]  = mk(2'd3, 2'd0, 1'b0, 2'd0, 1, LAT + 1, 1'b0, 1'b0);  // EXC_VEC
    vecs[7]  = mk(2'd2, 2'd3, 1'b0, 2'd0, 3, 1,       1'b0, 1'b0);  // STORE size 3 = word
    vecs[8]  = mk(2'd0, 2'd2, 1'b1, 2'd3, 0, LAT + 1, 1'b0, 1'b0);  // FETCH ignores size/lsb
`ifdef MEM_ALIGN_CHECK_EN
    vecs[9]  = mk(2'd1, 2'd1, 1'b0, 2'd1, 3, 1,       1'b1, 1'b0);  // LOAD HALF misaligned
    vecs[10] = mk(2'd2, 2'd0, 1'b1, 2'd2, 2, 1,       1'b1, 1'b0);  // STORE WORD misaligned
`else
    vecs[9]  = mk(2'd1, 2'd1, 1'b0, 2'd1, 3, LAT + 1, 1'b0, 1'b0);
    vecs[10] = mk(2'd2, 2'd0, 1'b1, 2'd2, 2, 1,       1'b0, 1'b0);
`endif
    vecs[11] = mk(2'd3, 2'd2, 1'b1, 2'd3, 1, LAT + 1, 1'b0, 1'b0);  // EXC_VEC ignores size/lsb

    req_valid = 1'b0; req_type = 2'd0; req_size = 2'd0; addr_from_alu = 1'b0; addr_lsb = 2'd0;
    reset = 1'b1;
    #1;
    chk("rst_ready", int'(req_ready), 1);
    chk("rst_iord", int'(iord_sel), 0);
    chk("rst_strb", strb(), 0);
    chk("rst_done", {30'd0, done, misalign}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back: STORE WORD then EXC_VEC with valid held through the busy cycle.
    @(negedge clk);
    begin
      int acc;
      acc = cyc;
      drive(2'd2, 2'd0, 1'b1, 2'd0);
      @(posedge clk);
      #1 drive(2'd3, 2'd0, 1'b0, 2'd0);
      @(negedge clk);
      chk("b2b_st_iord", int'(iord_sel), 2);
      chk("b2b_st_strb", strb(), 1);
      chk("b2b_st_done", int'(done), 1);
      chk("b2b_st_busy", int'(req_ready), 0);
      @(negedge clk);
      chk("b2b_idle_cyc", cyc - acc, 2);
      chk("b2b_idle_ready", int'(req_ready), 1);
      chk("b2b_idle_iord", int'(iord_sel), 0);
      chk("b2b_idle_done", int'(done), 0);
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int k = 3; k <= 2 + LAT + 1; k++) begin
        @(negedge clk);
        chk("b2b_exc_iord", int'(iord_sel), 1);
        chk("b2b_exc_strb", strb(), (k == 2 + LAT + 1) ? 4 : 0);
        chk("b2b_exc_done", int'(done), (k == 2 + LAT + 1) ? 1 : 0);
      end
    end

    // Reset mid-RD_WAIT clears outputs in the same cycle; next FETCH runs normally.
    @(negedge clk);
    drive(2'd1, 2'd0, 1'b0, 2'd0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rw_pre_iord", int'(iord_sel), 3);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rw_rst_ready", int'(req_ready), 1);
    chk("rw_rst_iord", int'(iord_sel), 0);
    chk("rw_rst_strb", strb(), 0);
    chk("rw_rst_done", int'(done), 0);
    @(negedge clk);
    reset = 1'b0;
    run_vec(vecs[0], "post_rst_fetch");

    // Reset during WRITE drops mem_wr immediately and never reports done.
    @(negedge clk);
    drive(2'd2, 2'd0, 1'b0, 2'd0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    #1;
    chk("wr_pre_memwr", int'(mem_wr), 1);
    reset = 1'b1;
    #1;
    chk("wr_rst_memwr", int'(mem_wr), 0);
    chk("wr_rst_done", int'(done), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("wr_rst_idle", int'(req_ready), 1);
    chk("wr_rst_quiet", strb(), 0);

    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
